// File: rtl/frontend_pkg.sv
// Frontend-wide constants and width helpers shared by the fetch queue and its neighbours.
package frontend_pkg;

  localparam int INSTR_W     = 32;
  localparam int EXCP_CODE_W = 4;

  // Width able to express any slot count 0..fetch_width.
  function automatic int take_w(input int fetch_width);
    return $clog2(fetch_width + 1);
  endfunction

  function automatic int off_w(input int fetch_width);
    return (fetch_width > 1) ? $clog2(fetch_width) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Icache-side push bus and decode-side pop bus of the fetch queue.
interface fetch_queue_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int PC_W        = 30,
  parameter int META_W      = 36
) ();

  localparam int TAKE_W = frontend_pkg::take_w(FETCH_WIDTH);

  logic                                            in_valid_i;
  logic                                            in_busy_o;
  logic [PC_W-1:0]                                 in_pc_i;
  logic [frontend_pkg::INSTR_W*FETCH_WIDTH-1:0]    in_instr_i;
  logic [FETCH_WIDTH-1:0]                          in_mask_i;
  logic                                            in_excp_vld_i;
  logic [frontend_pkg::EXCP_CODE_W-1:0]            in_excp_code_i;
  logic [META_W-1:0]                               in_meta_i;

  logic                                            out_valid_o;
  logic [PC_W-1:0]                                 out_pc_o;
  logic [frontend_pkg::INSTR_W*FETCH_WIDTH-1:0]    out_instr_o;
  logic [FETCH_WIDTH-1:0]                          out_mask_o;
  logic                                            out_excp_vld_o;
  logic [frontend_pkg::EXCP_CODE_W-1:0]            out_excp_code_o;
  logic [META_W-1:0]                               out_meta_o;
  logic [TAKE_W-1:0]                               out_take_i;

  modport slave (
    input  in_valid_i, in_pc_i, in_instr_i, in_mask_i, in_excp_vld_i, in_excp_code_i, in_meta_i,
    input  out_take_i,
    output in_busy_o,
    output out_valid_o, out_pc_o, out_instr_o, out_mask_o, out_excp_vld_o, out_excp_code_o, out_meta_o
  );

  modport master (
    output in_valid_i, in_pc_i, in_instr_i, in_mask_i, in_excp_vld_i, in_excp_code_i, in_meta_i,
    output out_take_i,
    input  in_busy_o,
    input  out_valid_o, out_pc_o, out_instr_o, out_mask_o, out_excp_vld_o, out_excp_code_o, out_meta_o
  );

endinterface

// File: rtl/fetch_queue_align.sv
// Head-entry realignment: shifts the undelivered slots down to slot 0 and reports how many remain.
module fetch_queue_align import frontend_pkg::*; #(
  parameter int FETCH_WIDTH = 2,
  parameter int PC_W        = 30,
  parameter int TAKE_W      = take_w(FETCH_WIDTH),
  parameter int OFF_W       = off_w(FETCH_WIDTH)
) (
  input  logic [INSTR_W*FETCH_WIDTH-1:0] instr_i,
  input  logic [FETCH_WIDTH-1:0]         mask_i,
  input  logic [PC_W-1:0]                pc_i,
  input  logic [OFF_W-1:0]               off_i,
  output logic [INSTR_W*FETCH_WIDTH-1:0] instr_o,
  output logic [FETCH_WIDTH-1:0]         mask_o,
  output logic [PC_W-1:0]                pc_o,
  output logic [TAKE_W-1:0]              rem_o
);

  logic [FETCH_WIDTH-1:0] mask_sh_s;
  logic [TAKE_W-1:0]      rem_s;

  // Slot shift by the head offset; slots shifted in from beyond the bundle read as empty.
  always_comb begin
    instr_o   = '0;
    mask_sh_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (i + int'(off_i) < FETCH_WIDTH) begin
        instr_o[i*INSTR_W +: INSTR_W] = instr_i[(i + int'(off_i))*INSTR_W +: INSTR_W];
        mask_sh_s[i]                  = mask_i[i + int'(off_i)];
      end else begin
        instr_o[i*INSTR_W +: INSTR_W] = '0;
        mask_sh_s[i]                  = 1'b0;
      end
    end
  end

  // Remaining-slot count and the contiguous mask rebuilt from it.
  always_comb begin
    rem_s  = '0;
    mask_o = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rem_s = rem_s + TAKE_W'(mask_sh_s[i]);
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask_o[i] = (i < int'(rem_s));
    end
  end

  assign rem_o = rem_s;
  assign pc_o  = pc_i + PC_W'(off_i);

endmodule

// File: rtl/fetch_queue_chk.sv
// Protocol checker: decode must never take more slots than the head bundle still holds.
module fetch_queue_chk #(
  parameter int TAKE_W = 2
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  input logic              valid,
  input logic [TAKE_W-1:0] take,
  input logic [TAKE_W-1:0] rem
);

  // Over-take or take from an empty queue (ignored on a flush cycle, where take has no effect).
  a_take_legal: assert property (@(posedge clk) disable iff (!rst_n || flush)
    (take != '0) |-> (valid && (take <= rem)));

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry flop-based queue of fetch bundles with partial consumption and slot realignment.
module fetch_queue import frontend_pkg::*; #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 4,
  parameter int PC_W        = 30,
  parameter int META_W      = 36,
  localparam int COUNT_W    = $clog2(DEPTH + 1)
) (
  input  logic               core_clock_i,
  input  logic               core_reset_ni,
  input  logic               flush_i,
  output logic [COUNT_W-1:0] count_o,
  fetch_queue_if.slave       fq
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int TAKE_W = take_w(FETCH_WIDTH);
  localparam int OFF_W  = off_w(FETCH_WIDTH);

  typedef struct packed {
    logic [PC_W-1:0]                pc;
    logic [INSTR_W*FETCH_WIDTH-1:0] instr;
    logic [FETCH_WIDTH-1:0]         mask;
    logic                           excp_vld;
    logic [EXCP_CODE_W-1:0]         excp_code;
    logic [META_W-1:0]              meta;
  } entry_t;

  entry_t             entry_q [DEPTH];
  entry_t             entry_d [DEPTH];
  entry_t             new_entry_s;
  entry_t             head_s;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [OFF_W-1:0]   off_q, off_d;

  logic               busy_s, valid_s, push_s, pop_s, adv_s;
  logic [TAKE_W-1:0]  rem_s;
  logic [FETCH_WIDTH-1:0] al_mask_s;

  assign head_s  = entry_q[rptr_q];
  assign busy_s  = (count_q == COUNT_W'(DEPTH));
  assign valid_s = (count_q != '0);

  fetch_queue_align #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .PC_W        (PC_W),
    .TAKE_W      (TAKE_W),
    .OFF_W       (OFF_W)
  ) u_align (
    .instr_i (head_s.instr),
    .mask_i  (head_s.mask),
    .pc_i    (head_s.pc),
    .off_i   (off_q),
    .instr_o (fq.out_instr_o),
    .mask_o  (al_mask_s),
    .pc_o    (fq.out_pc_o),
    .rem_o   (rem_s)
  );

  // Push/consume decode; empty bundles without an exception are dropped at the door.
  always_comb begin
    push_s = fq.in_valid_i && !busy_s && !flush_i && ((|fq.in_mask_i) || fq.in_excp_vld_i);
    pop_s  = valid_s && (fq.out_take_i != '0) && (fq.out_take_i == rem_s);
    adv_s  = valid_s && (fq.out_take_i != '0) && (fq.out_take_i < rem_s);
    new_entry_s.pc        = fq.in_pc_i;
    new_entry_s.instr     = fq.in_instr_i;
    new_entry_s.mask      = fq.in_excp_vld_i ? FETCH_WIDTH'(1) : fq.in_mask_i;
    new_entry_s.excp_vld  = fq.in_excp_vld_i;
    new_entry_s.excp_code = fq.in_excp_code_i;
    new_entry_s.meta      = fq.in_meta_i;
  end

  // Storage write port.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = (push_s && (wptr_q == PTR_W'(i))) ? new_entry_s : entry_q[i];
    end
  end

  // Pointer, occupancy and head-offset update; flush overrides push and take.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    off_d   = off_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      off_d   = '0;
    end else begin
      wptr_d  = push_s ? (wptr_q + PTR_W'(1)) : wptr_q;
      rptr_d  = pop_s ? (rptr_q + PTR_W'(1)) : rptr_q;
      count_d = count_q + COUNT_W'(push_s) - COUNT_W'(pop_s);
      if (pop_s) begin
        off_d = '0;
      end else if (adv_s) begin
        off_d = off_q + OFF_W'(fq.out_take_i);
      end else begin
        off_d = off_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge core_clock_i) begin
    if (!core_reset_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      off_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      off_q   <= off_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign count_o            = count_q;
  assign fq.in_busy_o       = busy_s;
  assign fq.out_valid_o     = valid_s;
  assign fq.out_mask_o      = valid_s ? al_mask_s : '0;
  assign fq.out_excp_vld_o  = head_s.excp_vld;
  assign fq.out_excp_code_o = head_s.excp_code;
  assign fq.out_meta_o      = head_s.meta;

  fetch_queue_chk #(.TAKE_W(TAKE_W)) u_chk (
    .clk   (core_clock_i),
    .rst_n (core_reset_ni),
    .flush (flush_i),
    .valid (valid_s),
    .take  (fq.out_take_i),
    .rem   (rem_s)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected slots are queued on accepted pushes and popped as decode takes them.
module tb_fetch_queue;

  localparam int FW    = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] instr;
  } slot_t;

  typedef struct {
    int          slots;
    logic        excp;
    logic [3:0]  code;
    logic [35:0] meta;
  } bun_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;

  slot_t sq[$];
  bun_t  bq[$];
  int    checks_cnt = 0;
  int    errors_cnt = 0;
  bit    chk_en     = 1'b0;

  fetch_queue_if #(.FETCH_WIDTH(FW), .PC_W(30), .META_W(36)) fq ();

  fetch_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .PC_W(30), .META_W(36)) dut (
    .core_clock_i  (clk),
    .core_reset_ni (rst_n),
    .flush_i       (flush),
    .count_o       (count),
    .fq            (fq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [29:0] pc, input int i);
    return {2'b10, pc + 30'(i)};
  endfunction

  function automatic int head_rem();
    return (bq.size() != 0) ? bq[0].slots : 0;
  endfunction

  // One clock: drive inputs, compare against the model, then advance the model past the edge.
  task automatic cycle(input logic rst_act, input logic vld, input logic [29:0] pc,
                       input logic [1:0] mask, input logic excp, input logic [3:0] code,
                       input int take, input logic fl);
    logic acc;
    int   rem;
    logic [63:0] instr_w;
    rst_n             = ~rst_act;
    flush             = fl;
    fq.in_valid_i     = vld;
    fq.in_pc_i        = pc;
    fq.in_instr_i     = {instr_of(pc, 1), instr_of(pc, 0)};
    fq.in_mask_i      = mask;
    fq.in_excp_vld_i  = excp;
    fq.in_excp_code_i = code;
    fq.in_meta_i      = {6'h2A, pc};
    fq.out_take_i     = 2'(take);
    #1;
    rem = head_rem();
    if (chk_en) begin
      check("out_valid", 64'(fq.out_valid_o), 64'(bq.size() != 0));
      check("count", 64'(count), 64'(bq.size()));
      check("in_busy", 64'(fq.in_busy_o), 64'(bq.size() == DEPTH));
      check("out_mask", 64'(fq.out_mask_o), 64'((1 << rem) - 1));
      if (rem != 0) begin
        instr_w = 64'(fq.out_instr_o);
        check("out_pc", 64'(fq.out_pc_o), 64'(sq[0].pc));
        for (int k = 0; k < rem; k++) begin
          check("out_instr", 64'(instr_w[k*32 +: 32]), 64'(sq[k].instr));
        end
        check("excp_vld", 64'(fq.out_excp_vld_o), 64'(bq[0].excp));
        if (bq[0].excp) check("excp_code", 64'(fq.out_excp_code_o), 64'(bq[0].code));
        check("out_meta", 64'(fq.out_meta_o), 64'(bq[0].meta));
      end
    end
    acc = !rst_act && vld && (bq.size() < DEPTH) && !fl && ((mask != 2'b00) || excp);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    if (rst_act || fl) begin
      sq.delete();
      bq.delete();
    end else begin
      if (take != 0 && bq.size() != 0) begin
        for (int k = 0; k < take; k++) void'(sq.pop_front());
        bq[0].slots -= take;
        if (bq[0].slots == 0) void'(bq.pop_front());
      end
      if (acc) begin
        bun_t b;
        int   n;
        n = excp ? 1 : ((mask == 2'b11) ? 2 : 1);
        b.slots = n;
        b.excp  = excp;
        b.code  = code;
        b.meta  = {6'h2A, pc};
        bq.push_back(b);
        for (int k = 0; k < n; k++) sq.push_back('{pc + 30'(k), instr_of(pc, k)});
      end
    end
  endtask

  task automatic idle(input int take);
    cycle(1'b0, 1'b0, 30'h0, 2'b00, 1'b0, 4'h0, take, 1'b0);
  endtask

  task automatic push(input logic [29:0] pc, input logic [1:0] mask, input int take);
    cycle(1'b0, 1'b1, pc, mask, 1'b0, 4'h0, take, 1'b0);
  endtask

  initial begin
    // reset held for two cycles, then a single two-slot bundle
    cycle(1'b1, 1'b0, 30'h0, 2'b00, 1'b0, 4'h0, 0, 1'b0);
    cycle(1'b1, 1'b0, 30'h0, 2'b00, 1'b0, 4'h0, 0, 1'b0);
    push(30'h100, 2'b11, 0);
    // partial take then finishing take
    idle(1);
    idle(1);
    idle(0);

    // fill, refused fifth push, full-with-pop refusal, then drain
    for (int i = 0; i < DEPTH; i++) push(30'h200 + 30'(16 * i), 2'b11, 0);
    push(30'h240, 2'b11, 0);
    push(30'h250, 2'b11, head_rem());
    check("busy_release", 64'(fq.in_busy_o), 64'h0);
    while (bq.size() != 0) idle(head_rem());
    idle(0);

    // streaming with take=rem each cycle across pointer wrap
    for (int i = 0; i < 10; i++) begin
      push(30'h300 + 30'(8 * i), (i % 3 == 0) ? 2'b01 : 2'b11, head_rem());
      check("stream_cnt_le2", 64'(count <= 3'd2), 64'h1);
    end
    while (bq.size() != 0) idle(head_rem());

    // flush mid-bundle with concurrent push and take
    push(30'h400, 2'b11, 0);
    push(30'h410, 2'b11, 0);
    push(30'h420, 2'b11, 0);
    idle(1);
    cycle(1'b0, 1'b1, 30'h430, 2'b11, 1'b0, 4'h0, 1, 1'b1);
    check("flush_empty", 64'(fq.out_valid_o), 64'h0);
    push(30'h440, 2'b11, 0);
    idle(0);
    idle(2);

    // exception bundle stored as one slot, empty bundle dropped
    cycle(1'b0, 1'b1, 30'h500, 2'b00, 1'b1, 4'h1, 0, 1'b0);
    push(30'h510, 2'b00, 0);
    cycle(1'b0, 1'b1, 30'h520, 2'b11, 1'b1, 4'h7, 0, 1'b0);
    idle(1);
    idle(1);
    idle(0);

    // reset while occupied
    push(30'h600, 2'b11, 0);
    cycle(1'b1, 1'b0, 30'h0, 2'b00, 1'b0, 4'h0, 0, 1'b0);
    idle(0);

    // randomised traffic with legal takes
    for (int i = 0; i < 300; i++) begin
      logic [1:0] m;
      int r;
      r = $urandom_range(0, 2);
      m = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      cycle(1'b0, 1'($urandom_range(0, 1)), 30'($urandom), m,
            ($urandom_range(0, 9) == 0), 4'($urandom), $urandom_range(0, head_rem()),
            ($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch-bundle queue between the instruction cache and the decode stage of the frontend. It replaces the fixed single-bundle hand-off with a DEPTH-entry buffer of FETCH_WIDTH-slot bundles. Decode can consume a bundle partially, a variable number of slots per cycle, and the queue realigns the remaining slots to slot 0. BTB metadata and fetch exceptions travel with each bundle, and the whole queue is discarded on pipeline flush or branch correction.

## Interface
- FETCH_WIDTH, 2, instruction slots per bundle (≥1)
- DEPTH, 4, bundle entries (power of two, ≥2)
- PC_W, 30, word-address PC width
- META_W, 36, opaque BTB metadata width (btype, bm_pred, target, vld, idx, way)
- core_clock_i  in  1  core clock
- core_reset_ni  in  1  reset, synchronous, active-low
- flush_i  in  1  discard all contents (core flush | branch correct)
- in_valid_i  in  1  bundle offered by icache
- in_busy_o  out  1  queue cannot accept a bundle this cycle
- in_pc_i  in  PC_W  PC of slot 0
- in_instr_i  in  32·FETCH_WIDTH  instructions, slot i at bits [32i+31:32i]
- in_mask_i  in  FETCH_WIDTH  valid slots; contiguous from bit 0
- in_excp_vld_i  in  1  fetch exception on this bundle
- in_excp_code_i  in  4  exception code
- in_meta_i  in  META_W  BTB metadata
- out_valid_o  out  1  head bundle has ≥1 undelivered slot
- out_pc_o  out  PC_W  PC of delivered slot 0 (entry PC + head offset)
- out_instr_o  out  32·FETCH_WIDTH  remaining slots shifted to slot 0
- out_mask_o  out  FETCH_WIDTH  valid remaining slots, contiguous from bit 0
- out_excp_vld_o / out_excp_code_o  out  1 / 4  head exception
- out_meta_o  out  META_W  head metadata, unchanged by offset
- out_take_i  in  clog2(FETCH_WIDTH+1)  slots decode consumes this cycle
- count_o  out  clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular array of DEPTH entries {pc, instr, mask, excp_vld, excp_code, meta}. Write pointer, read pointer and count. Head slot offset `off` ranges 0..FETCH_WIDTH-1.
- Push when in_valid_i & !in_busy_o & !flush_i. A bundle with mask==0 and no exception is dropped and not written.
- Exception bundle: stored mask is forced to 1 (slot 0 only). It is delivered as one slot and popped by take=1.
- rem = popcount(mask >> off) of the head entry. out_valid_o = count≠0. out_mask_o = (1<<rem)-1.
- Consume:
  - take==rem: pop the head and set off=0.
  - 0<take<rem: off += take, head stays.
  - take==0: no change.
  - take>rem, or take≠0 while !out_valid_o: illegal, caught by assertion. The design does not guard against it.
- in_busy_o = (count==DEPTH). It does not look ahead to a same-cycle pop.
- Simultaneous push and pop: both take effect and count is unchanged. Pointers wrap modulo DEPTH.
- Flush: takes priority over push and take in the same cycle. On the next cycle count=0, off=0 and both pointers are 0.
- Reset: same state as flush.

## Timing
- Push to out_valid_o: 1 cycle. There is no empty bypass.
- All outputs are driven from registered state and combinational head-read/align logic. in_busy_o depends only on count.
- Reset values: out_valid_o=0, in_busy_o=0, count_o=0. out_mask_o=0 while empty. Data outputs are don't-care while out_valid_o=0.
- Throughput: one bundle in per cycle, up to FETCH_WIDTH slots out per cycle.
- Full with a pop in the same cycle: the push is refused that cycle. in_busy_o deasserts the following cycle.
- When flush is asserted on cycle N, out_valid_o=0 on cycle N+1 and a new push is accepted on cycle N+1.

## Structure
- Shared package frontend_pkg holds INSTR_W=32, EXCP_CODE_W=4 and the take/offset width helper functions.
- Sub-module fetch_queue_align is combinational. It takes {instr, mask, pc, off} and produces the shifted instructions, out_mask, out_pc and rem.
- Storage is flops, not SRAM.

## Test plan
- Reset and empty: hold core_reset_ni=0 for 2 cycles, then push pc=0x100 mask=11. Required: out_valid_o=0 during reset; out_valid_o=1 one cycle after the push, with out_pc_o=0x100 and out_mask_o=11.
- Partial take: head pc=0x100 mask=11, instructions A,B; take=1. Next cycle: out_pc_o=0x101, slot0=B, out_mask_o=01, count_o=1. Then take=1: the entry pops and count_o=0.
- Fill and backpressure: push 4 bundles with take=0. Required: count_o=4 and in_busy_o=1. A 5th push is ignored. Take the full head: count_o=3 and in_busy_o=0 next cycle.
- Wrap with concurrent push/pop: stream 10 bundles with take=rem every cycle. Required: PCs exit in order, count_o stays ≤2, and pointers wrap correctly.
- Flush mid-bundle: off=1 with count_o=3; assert flush_i with a simultaneous push and take=1. Next cycle: count_o=0, out_valid_o=0, and the pushed bundle is absent.
- Exception and drop: push excp_vld=1, code=1, mask=00; then push mask=00 with no exception. Required: one entry is stored, out_mask_o=01, out_excp_code_o=1, and take=1 empties the queue.
